// File: rtl/stitch_pipeline_add_vr.sv
// Elastic adder pipeline: x + y enters stage 1, then moves through STAGES valid/ready register stages.
// Define STITCH_PIPELINE_SAT_EN to clamp the stage-1 sum to all-ones on carry-out.
module stitch_pipeline_add_vr #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 2,
  parameter int CNT_W  = $clog2(STAGES + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic             out_carry,
  output logic [CNT_W-1:0] occupancy
);

  logic [STAGES:1] vld_p;
  logic [STAGES:1] vld_next;
  logic [STAGES:1] rdy;
  logic [WIDTH:0]  data_p [1:STAGES];
  logic [WIDTH:0]  sum_p0;

  function automatic logic [WIDTH:0] add_p0(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    logic [WIDTH:0] s;
    s = {1'b0, a} + {1'b0, b};
`ifdef STITCH_PIPELINE_SAT_EN
    if (s[WIDTH]) s[WIDTH-1:0] = '1;
`endif
    return s;
  endfunction

  function automatic logic [CNT_W-1:0] popcount(input logic [STAGES:1] v);
    logic [CNT_W-1:0] c;
    c = '0;
    for (int i = 1; i <= STAGES; i++) c = c + CNT_W'(v[i]);
    return c;
  endfunction

  // A stage is ready when it, or any stage after it, has a free slot, or the consumer takes the head.
  always_comb begin
    logic acc;
    acc = out_ready;
    rdy = '0;
    for (int i = STAGES; i >= 1; i--) begin
      acc    = acc || !vld_p[i];
      rdy[i] = acc;
    end
  end

  always_comb begin
    vld_next    = vld_p;
    vld_next[1] = rdy[1] ? in_valid : vld_p[1];
    for (int i = 2; i <= STAGES; i++) begin
      if (rdy[i]) vld_next[i] = vld_p[i-1];
    end
  end

  assign sum_p0 = add_p0(x, y);

  // Stage boundary: stage 1 captures the sum, later stages shift forward when free to do so.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p     <= '0;
      occupancy <= '0;
      for (int i = 1; i <= STAGES; i++) data_p[i] <= '0;
    end else begin
      vld_p     <= vld_next;
      occupancy <= popcount(vld_next);
      if (rdy[1] && in_valid) data_p[1] <= sum_p0;
      for (int i = 2; i <= STAGES; i++) begin
        if (rdy[i] && vld_p[i-1]) data_p[i] <= data_p[i-1];
      end
    end
  end

  assign in_ready  = rdy[1];
  assign out_valid = vld_p[STAGES];
  assign out       = data_p[STAGES][WIDTH-1:0];
  assign out_carry = data_p[STAGES][WIDTH];

endmodule

// File: tb/tb_stitch_pipeline_add_vr.sv
// Bench for stitch_pipeline_add_vr: three instances (32/2, 8/1, 16/5) against an ordered-queue reference.
module tb_stitch_pipeline_add_vr;

  logic clk;
  logic rst_n;

  logic        iv   [3];
  logic        ordy [3];
  logic [31:0] xs   [3];
  logic [31:0] ys   [3];
  logic        i_ready [3];
  logic        o_valid [3];
  logic        o_carry [3];
  logic [31:0] o_out   [3];
  logic [2:0]  o_occ   [3];

  logic        rdy0, ov0, oc0, rdy1, ov1, oc1, rdy2, ov2, oc2;
  logic [31:0] out0;
  logic [7:0]  out1;
  logic [15:0] out2;
  logic [1:0]  occ0;
  logic [0:0]  occ1;
  logic [2:0]  occ2;

  int vectors = 0;
  int miscompares = 0;
  int wid [3] = '{32, 8, 16};
  int stg [3] = '{2, 1, 5};

  logic [32:0] q0[$], q1[$], q2[$];

  stitch_pipeline_add_vr #(.WIDTH(32), .STAGES(2)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[0]), .in_ready(rdy0), .x(xs[0]), .y(ys[0]),
    .out_valid(ov0), .out_ready(ordy[0]), .out(out0), .out_carry(oc0), .occupancy(occ0));
  stitch_pipeline_add_vr #(.WIDTH(8), .STAGES(1)) dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[1]), .in_ready(rdy1), .x(xs[1][7:0]), .y(ys[1][7:0]),
    .out_valid(ov1), .out_ready(ordy[1]), .out(out1), .out_carry(oc1), .occupancy(occ1));
  stitch_pipeline_add_vr #(.WIDTH(16), .STAGES(5)) dut16 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[2]), .in_ready(rdy2), .x(xs[2][15:0]), .y(ys[2][15:0]),
    .out_valid(ov2), .out_ready(ordy[2]), .out(out2), .out_carry(oc2), .occupancy(occ2));

  assign i_ready[0] = rdy0;  assign i_ready[1] = rdy1;  assign i_ready[2] = rdy2;
  assign o_valid[0] = ov0;   assign o_valid[1] = ov1;   assign o_valid[2] = ov2;
  assign o_carry[0] = oc0;   assign o_carry[1] = oc1;   assign o_carry[2] = oc2;
  assign o_out[0]   = out0;  assign o_out[1] = 32'(out1);  assign o_out[2] = 32'(out2);
  assign o_occ[0]   = 3'(occ0);  assign o_occ[1] = 3'(occ1);  assign o_occ[2] = occ2;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [63:0] mask_of(int k);
    return (64'd1 << wid[k]) - 64'd1;
  endfunction

  // Reference: unsigned add at full precision, carry is bit WIDTH, optional clamp.
  function automatic logic [32:0] ref_add(int k, logic [31:0] a, logic [31:0] b);
    logic [63:0] s;
    logic        c;
    logic [63:0] m;
    m = mask_of(k);
    s = {32'd0, a} + {32'd0, b};
    c = s[wid[k]];
    s = s & m;
`ifdef STITCH_PIPELINE_SAT_EN
    if (c) s = m;
`endif
    return {c, s[31:0]};
  endfunction

  task automatic check(string tag, logic [63:0] obs, logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push(int k, logic [32:0] v);
    case (k)
      0: q0.push_back(v);
      1: q1.push_back(v);
      default: q2.push_back(v);
    endcase
  endtask

  function automatic int qsize(int k);
    case (k)
      0: return q0.size();
      1: return q1.size();
      default: return q2.size();
    endcase
  endfunction

  task automatic pop(int k, output logic [32:0] v);
    case (k)
      0: v = q0.pop_front();
      1: v = q1.pop_front();
      default: v = q2.pop_front();
    endcase
  endtask

  task automatic clear_model();
    q0.delete(); q1.delete(); q2.delete();
  endtask

  // Called with inputs already driven after a falling edge; returns at the next falling edge.
  task automatic tick();
    logic [32:0] e;
    #1;
    for (int k = 0; k < 3; k++) begin
      if (o_valid[k] && ordy[k]) begin
        if (qsize(k) == 0) check($sformatf("unexpected_output[%0d]", k), 64'(o_out[k]), 64'hDEAD);
        else begin
          pop(k, e);
          check($sformatf("result[%0d]", k), {31'd0, o_carry[k], o_out[k]}, {31'd0, e});
        end
      end
      if (iv[k] && i_ready[k]) push(k, ref_add(k, xs[k], ys[k]));
    end
    @(posedge clk);
    #1;
    for (int k = 0; k < 3; k++)
      check($sformatf("occupancy[%0d]", k), 64'(o_occ[k]), 64'(qsize(k)));
    @(negedge clk);
  endtask

  task automatic check_idle(string tag);
    for (int k = 0; k < 3; k++) begin
      check($sformatf("%s_out_valid[%0d]", tag, k), 64'(o_valid[k]), 64'd0);
      check($sformatf("%s_out[%0d]", tag, k), {31'd0, o_carry[k], o_out[k]}, 64'd0);
      check($sformatf("%s_occupancy[%0d]", tag, k), 64'(o_occ[k]), 64'd0);
      check($sformatf("%s_in_ready[%0d]", tag, k), 64'(i_ready[k]), 64'd1);
    end
  endtask

  initial begin
    int lat [3];
    logic [31:0] held;
    rst_n = 1'b0;
    for (int k = 0; k < 3; k++) begin
      iv[k] = 1'b0; ordy[k] = 1'b1; xs[k] = '0; ys[k] = '0;
    end
    repeat (3) @(posedge clk);
    #1 check_idle("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Basic: 42 + 64 after exactly two edges, occupancy 1,1,0.
    iv[0] = 1'b1; xs[0] = 32'd42; ys[0] = 32'd64;
    tick();
    iv[0] = 1'b0;
    check("basic_valid_early", 64'(o_valid[0]), 64'd0);
    check("basic_occ1", 64'(o_occ[0]), 64'd1);
    tick();
    check("basic_valid", 64'(o_valid[0]), 64'd1);
    check("basic_out", {31'd0, o_carry[0], o_out[0]}, 64'd106);
    check("basic_occ2", 64'(o_occ[0]), 64'd1);
    tick();
    check("basic_occ3", 64'(o_occ[0]), 64'd0);
    check("basic_valid_gone", 64'(o_valid[0]), 64'd0);

    // Streaming: eight back-to-back items, outputs on eight consecutive cycles.
    for (int c = 0; c < 10; c++) begin
      iv[0] = (c < 8); xs[0] = 32'(c); ys[0] = 32'(2 * c);
      if (c < 8) check("stream_in_ready", 64'(i_ready[0]), 64'd1);
      tick();
      check("stream_valid", 64'(o_valid[0]), 64'((c >= 1) && (c <= 8)));
      if (c >= 1 && c <= 8) check("stream_out", 64'(o_out[0]), 64'(3 * (c - 1)));
    end
    iv[0] = 1'b0;

    // Backpressure: 1 and 2 fill the pipe, 3 is held off until the consumer releases.
    ordy[0] = 1'b0;
    for (int c = 1; c <= 3; c++) begin
      iv[0] = 1'b1; xs[0] = 32'(c); ys[0] = 32'd0;
      #1 check("bp_in_ready", 64'(i_ready[0]), 64'(c < 3));
      tick();
    end
    check("bp_occ_full", 64'(o_occ[0]), 64'd2);
    check("bp_head", 64'(o_out[0]), 64'd1);
    tick();
    check("bp_head_stable", 64'(o_out[0]), 64'd1);
    check("bp_valid_stable", 64'(o_valid[0]), 64'd1);
    ordy[0] = 1'b1;
    #1 check("bp_release_ready", 64'(i_ready[0]), 64'd1);
    tick();
    iv[0] = 1'b0;
    check("bp_occ_same", 64'(o_occ[0]), 64'd2);
    check("bp_second", 64'(o_out[0]), 64'd2);
    tick();
    check("bp_third", 64'(o_out[0]), 64'd3);
    tick();
    check("bp_drained", 64'(o_valid[0]), 64'd0);

    // Overflow: all-ones + 1.
    iv[0] = 1'b1; xs[0] = 32'hFFFF_FFFF; ys[0] = 32'd1;
    tick();
    iv[0] = 1'b0;
    tick();
`ifdef STITCH_PIPELINE_SAT_EN
    check("overflow_out", 64'(o_out[0]), 64'hFFFF_FFFF);
`else
    check("overflow_out", 64'(o_out[0]), 64'd0);
`endif
    check("overflow_carry", 64'(o_carry[0]), 64'd1);
    tick();

    // Latency on every instance.
    for (int k = 0; k < 3; k++) begin
      lat[k] = 0; xs[k] = $urandom & 32'(mask_of(k)); ys[k] = $urandom & 32'(mask_of(k));
    end
    for (int t = 1; t <= 8; t++) begin
      for (int k = 0; k < 3; k++) iv[k] = (t == 1);
      tick();
      for (int k = 0; k < 3; k++) if (lat[k] == 0 && o_valid[k]) lat[k] = t;
    end
    for (int k = 0; k < 3; k++) check($sformatf("latency[%0d]", k), 64'(lat[k]), 64'(stg[k]));

    // Stall: occupancy peaks at STAGES and input is refused.
    for (int k = 0; k < 3; k++) begin ordy[k] = 1'b0; iv[k] = 1'b1; end
    for (int t = 0; t < 7; t++) begin
      for (int k = 0; k < 3; k++) begin
        xs[k] = $urandom & 32'(mask_of(k)); ys[k] = $urandom & 32'(mask_of(k));
      end
      tick();
    end
    #1;
    for (int k = 0; k < 3; k++) begin
      check($sformatf("peak_occ[%0d]", k), 64'(o_occ[k]), 64'(stg[k]));
      check($sformatf("full_in_ready[%0d]", k), 64'(i_ready[k]), 64'd0);
    end
    for (int k = 0; k < 3; k++) begin ordy[k] = 1'b1; iv[k] = 1'b0; end
    repeat (7) tick();

    // Mid-operation asynchronous reset with items in flight.
    iv[0] = 1'b1; ordy[0] = 1'b0;
    tick(); tick();
    iv[0] = 1'b0;
    check("pre_reset_occ", 64'(o_occ[0]), 64'd2);
    #2 rst_n = 1'b0;
    #1 check_idle("async_reset");
    clear_model();
    @(negedge clk);
    rst_n = 1'b1;
    ordy[0] = 1'b1;
    iv[0] = 1'b1; xs[0] = 32'd5; ys[0] = 32'd6;
    tick();
    iv[0] = 1'b0;
    tick();
    check("post_reset_valid", 64'(o_valid[0]), 64'd1);
    check("post_reset_out", 64'(o_out[0]), 64'd11);
    tick();

    // Random valid/ready traffic on all instances.
    for (int c = 0; c < 1800; c++) begin
      for (int k = 0; k < 3; k++) begin
        iv[k]   = ($urandom_range(3) != 0);
        ordy[k] = ($urandom_range(9) < 7);
        xs[k]   = ($urandom_range(7) == 0) ? 32'(mask_of(k)) : ($urandom & 32'(mask_of(k)));
        ys[k]   = $urandom & 32'(mask_of(k));
      end
      if (o_valid[0] && !ordy[0]) held = o_out[0];
      tick();
      if (o_valid[0] && !ordy[0] && c > 0) begin
        // nothing further: stability is enforced through the ordered scoreboard
      end
    end
    for (int k = 0; k < 3; k++) begin iv[k] = 1'b0; ordy[k] = 1'b1; end
    repeat (8) tick();
    for (int k = 0; k < 3; k++) check($sformatf("drained[%0d]", k), 64'(qsize(k)), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/stitch_pipeline_add_vr.md
Name: stitch_pipeline_add_vr

Overview:
- Parametrised successor to the fixed two-stage stitched adder pipeline.
- Adds two WIDTH-bit operands and carries the sum plus carry-out through STAGES pipeline register stages.
- Each stage has a valid/ready (elastic) handshake, so downstream stalls are absorbed without losing or duplicating data.
- Sits between DSLX-generated stage logic and a stream consumer; also reports the number of items in flight.

Parameters:
- WIDTH, 32, operand and sum width in bits (>=1).
- STAGES, 2, number of pipeline register stages between input and output (>=1).
- CNT_W, $clog2(STAGES+1), width of the occupancy count.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  operands x/y valid this cycle.
- in_ready  output  1  pipeline accepts operands this cycle.
- x  input  WIDTH  operand a.
- y  input  WIDTH  operand b.
- out_valid  output  1  out/out_carry hold a result.
- out_ready  input  1  consumer accepts the result this cycle.
- out  output  WIDTH  sum.
- out_carry  output  1  carry-out of the add (overflow flag).
- occupancy  output  CNT_W  number of valid stage registers.

Behaviour:
- Reset is asynchronous: rst_n low clears every stage valid bit and data register to 0, immediately and regardless of clk.
  - Outputs during and after reset: out_valid=0, out=0, out_carry=0, occupancy=0, in_ready=1.
  - Reset asserted mid-operation drops all in-flight items; nothing is replayed.
- Stage 1 captures {carry, sum} = x + y, computed at WIDTH+1 bits. Stages 2..STAGES pass data through unchanged.
- Per-stage ready: rdy[i] = !v[i] || rdy[i+1], with rdy[STAGES+1] = out_ready.
  - in_ready = rdy[1], a combinational path from out_ready.
- Stage i loads when rdy[i] is 1:
  - v[i] <= v[i-1], where v[0] = in_valid.
  - The data register loads only when the incoming valid is 1. Otherwise it holds its old value, but is qualified invalid.
- A stalled stage (v[i]=1 and rdy[i]=0) holds its data and valid bit exactly.
- Outputs are driven directly from the last stage: out_valid = v[STAGES], out/out_carry = last stage data.
- Handshakes:
  - An input transfer occurs when in_valid && in_ready.
  - An output transfer occurs when out_valid && out_ready.
  - out_valid, once high, stays high and out stays stable until out_ready is seen.
- Latency and throughput:
  - Latency is exactly STAGES cycles from input transfer to out_valid when no stall occurs.
  - Throughput is 1 item per cycle with out_ready held high.
- Full: all STAGES valid and out_ready=0, giving in_ready=0; an input presented then is not accepted.
- Full with out_ready=1: the whole pipe advances and accepts a new input in the same cycle, so occupancy is unchanged.
- Bubbles collapse: an empty stage accepts even while a downstream stage is stalled.
- occupancy = popcount of v[1..STAGES], updated registered alongside the valid bits.
  - Simultaneous input and output transfer leaves it unchanged.
  - It never exceeds STAGES.
- Arithmetic:
  - Unsigned and modular.
  - out_carry = bit WIDTH of the WIDTH+1-bit sum.
  - Example: all-ones + 1 gives out=0, out_carry=1.
- The in_valid=0 data path is don't-care on x/y; x/y values are never captured.

Optional Feature:
- Macro: STITCH_PIPELINE_SAT_EN.
- Defined: stage 1 saturates. When the carry is 1, the sum is forced to all-ones (2^WIDTH-1), and out_carry still reports 1 to flag the clamp.
- Undefined: wrap-around modular sum as above; no saturation logic is synthesised.
- Handshake, latency and occupancy are identical in both builds.

Test Plan:
- Reset/basic: rst_n low for 3 cycles, then x=42, y=64, in_valid=1 for one cycle, out_ready=1 (WIDTH=32, STAGES=2) -> out_valid rises exactly 2 cycles later with out=106, out_carry=0; occupancy goes 1,1,0.
- Streaming: 8 back-to-back inputs x=i, y=2i (i=0..7) with out_ready=1 -> 8 consecutive out_valid cycles with out=3i in order; in_ready stays 1 throughout.
- Backpressure: fill with x=1..3, y=0 while out_ready=0 (STAGES=2) -> the 3rd input is held off (in_ready=0), occupancy=2, and out=1 is stable. Then release out_ready -> results 1, 2, 3 emerge in order with none lost or duplicated.
- Overflow: x=32'hFFFF_FFFF, y=1 -> out=0, out_carry=1. With STITCH_PIPELINE_SAT_EN defined -> out=32'hFFFF_FFFF, out_carry=1.
- Mid-operation reset: 2 items in flight, rst_n pulsed low asynchronously between clock edges -> out_valid=0 and occupancy=0 immediately; after release, the first new input emerges after STAGES cycles.
- Parameter sweep: WIDTH=8, STAGES=1 and WIDTH=16, STAGES=5 -> latency equals STAGES, occupancy peaks at STAGES under a stall, and a random valid/ready scoreboard shows no mismatches over 1000 items.
